// File: rtl/led_sdo_rx.sv
// Oversampling receiver for the LED output link: recovers one WORD_W-bit word per
// lane from cko/sdo, and flags frame completion or a truncated frame.
module led_sdo_rx #(
    parameter int LANES           = 8,
    parameter int WORD_W          = 12,
    parameter int WORDS_PER_FRAME = 1,
    parameter int IDLE_TIMEOUT    = 64
) (
    input  logic                      clk_fast,
    input  logic                      rstn,
    input  logic                      en,
    input  logic                      cko_i,
    input  logic [LANES-1:0]          sdo_i,
    output logic                      word_valid,
    output logic [LANES*WORD_W-1:0]   word_data,
    output logic [7:0]                word_idx,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int BW = $clog2(WORD_W);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_RECV   = 1'b1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
    localparam logic [7:0]    WORD_LAST = 8'(WORDS_PER_FRAME - 1);
    localparam logic [IW-1:0] IDLE_SAT  = IW'(IDLE_TIMEOUT);
    localparam logic [IW-1:0] IDLE_HIT  = IW'(IDLE_TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);
    localparam logic [IW-1:0] IDLE_ZERO = IW'(0);

    logic                          cko_s1_q, cko_s2_q, cko_s3_q;
    logic [LANES-1:0]              sdo_s1_q, sdo_s2_q;
    logic [0:0]                    state_q, state_d;
    logic [BW-1:0]                 bit_cnt_q, bit_cnt_d;
    logic [7:0]                    word_cnt_q, word_cnt_d;
    logic [IW-1:0]                 idle_cnt_q, idle_cnt_d;
    logic [LANES-1:0][WORD_W-1:0]  sh_q, sh_d;
    logic                          word_valid_q, word_valid_d;
    logic [LANES*WORD_W-1:0]       word_data_q, word_data_d;
    logic [7:0]                    word_idx_q, word_idx_d;
    logic                          frame_done_q, frame_done_d;
    logic                          frame_err_q, frame_err_d;
    logic                          busy_q;
    logic                          rise_s;

    // Next-state logic: bit sampling, word/frame completion, idle timeout and enable gating.
    always_comb begin
        rise_s       = cko_s2_q & ~cko_s3_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        sh_d         = sh_q;
        word_valid_d = 1'b0;
        word_data_d  = word_data_q;
        word_idx_d   = word_idx_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        if (!en) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = BIT_ZERO;
            word_cnt_d = 8'd0;
            idle_cnt_d = IDLE_ZERO;
        end else if (rise_s) begin
            idle_cnt_d = IDLE_ZERO;
            for (int i = 0; i < LANES; i++) begin
                sh_d[i] = {sh_q[i][WORD_W-2:0], sdo_s2_q[i]};
            end
            if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d    = BIT_ZERO;
                word_valid_d = 1'b1;
                word_idx_d   = word_cnt_q;
                word_data_d  = sh_d;
                if (word_cnt_q == WORD_LAST) begin
                    frame_done_d = 1'b1;
                    word_cnt_d   = 8'd0;
                    state_d      = ST_IDLE;
                end else begin
                    word_cnt_d = word_cnt_q + 8'd1;
                    state_d    = ST_RECV;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_ONE;
                state_d   = ST_RECV;
            end
        end else begin
            if (idle_cnt_q != IDLE_SAT) begin
                idle_cnt_d = idle_cnt_q + IDLE_ONE;
            end else begin
                idle_cnt_d = idle_cnt_q;
            end
            // The partial word is dropped; word_data keeps the last good word.
            if ((state_q == ST_RECV) && (idle_cnt_q == IDLE_HIT)) begin
                frame_err_d = (bit_cnt_q != BIT_ZERO) || (word_cnt_q != 8'd0);
                bit_cnt_d   = BIT_ZERO;
                word_cnt_d  = 8'd0;
                state_d     = ST_IDLE;
            end else begin
                state_d = state_d;
            end
        end
    end

    // State, synchronizer and output registers with synchronous active-low reset.
    always_ff @(posedge clk_fast) begin
        if (!rstn) begin
            cko_s1_q     <= 1'b0;
            cko_s2_q     <= 1'b0;
            cko_s3_q     <= 1'b0;
            sdo_s1_q     <= {LANES{1'b0}};
            sdo_s2_q     <= {LANES{1'b0}};
            state_q      <= ST_IDLE;
            bit_cnt_q    <= BIT_ZERO;
            word_cnt_q   <= 8'd0;
            idle_cnt_q   <= IDLE_ZERO;
            sh_q         <= {(LANES*WORD_W){1'b0}};
            word_valid_q <= 1'b0;
            word_data_q  <= {(LANES*WORD_W){1'b0}};
            word_idx_q   <= 8'd0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cko_s1_q     <= cko_i;
            cko_s2_q     <= cko_s1_q;
            cko_s3_q     <= cko_s2_q;
            sdo_s1_q     <= sdo_i;
            sdo_s2_q     <= sdo_s1_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            sh_q         <= sh_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_idx_q   <= word_idx_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= (state_d == ST_RECV);
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign word_idx   = word_idx_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_led_sdo_rx.sv
// Directed-plus-random bench for led_sdo_rx: one single-word-frame instance and
// one three-word-frame instance share the link, each with its own enable.
module tb_led_sdo_rx;

    localparam int LANES = 8;
    localparam int WW    = 12;
    localparam int DW    = LANES * WW;
    localparam int TMO   = 64;

    typedef struct {
        logic [DW-1:0] data;
        logic [7:0]    idx;
        logic          done;
        int            cyc;
    } ev_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            en1 = 1'b0;
    logic            en3 = 1'b0;
    logic            cko = 1'b0;
    logic [LANES-1:0] sdo = '0;

    logic            wv1, fd1, fe1, bz1;
    logic [DW-1:0]   wd1;
    logic [7:0]      wi1;
    logic            wv3, fd3, fe3, bz3;
    logic [DW-1:0]   wd3;
    logic [7:0]      wi3;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  stray1 = 0;
    int  stray3 = 0;
    int  last_rise = 0;
    ev_t wv1_q[$];
    ev_t wv3_q[$];
    int  err1_q[$];
    int  err3_q[$];

    led_sdo_rx #(.LANES(LANES), .WORD_W(WW), .WORDS_PER_FRAME(1), .IDLE_TIMEOUT(TMO)) dut1 (
        .clk_fast(clk), .rstn(rstn), .en(en1), .cko_i(cko), .sdo_i(sdo),
        .word_valid(wv1), .word_data(wd1), .word_idx(wi1),
        .frame_done(fd1), .frame_err(fe1), .busy(bz1)
    );

    led_sdo_rx #(.LANES(LANES), .WORD_W(WW), .WORDS_PER_FRAME(3), .IDLE_TIMEOUT(TMO)) dut3 (
        .clk_fast(clk), .rstn(rstn), .en(en3), .cko_i(cko), .sdo_i(sdo),
        .word_valid(wv3), .word_data(wd3), .word_idx(wi3),
        .frame_done(fd3), .frame_err(fe3), .busy(bz3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every pulse is captured so no one-cycle event can be missed.
    always @(negedge clk) begin
        if (wv1) wv1_q.push_back('{wd1, wi1, fd1, cyc});
        if (fd1 && !wv1) stray1 <= stray1 + 1;
        if (fe1) err1_q.push_back(cyc);
        if (wv3) wv3_q.push_back('{wd3, wi3, fd3, cyc});
        if (fd3 && !wv3) stray3 <= stray3 + 1;
        if (fe3) err3_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first n bits (MSB first) of every lane word; sdo changes with cko falling.
    task automatic send_pulses(input logic [DW-1:0] w, input int n, input int hi, input int lo);
        for (int b = WW - 1; b >= WW - n; b--) begin
            cko = 1'b0;
            for (int i = 0; i < LANES; i++) sdo[i] = w[WW*i + b];
            cycles(lo);
            cko = 1'b1;
            last_rise = cyc;
            cycles(hi);
        end
        cko = 1'b0;
        cycles(lo);
    endtask

    function automatic int qsize(input int sel);
        return (sel == 1) ? wv1_q.size() : wv3_q.size();
    endfunction

    task automatic expect_word(input string tag, input int sel, input logic [DW-1:0] d,
                               input logic [7:0] idx, input logic done);
        int  n;
        ev_t e;
        n = 0;
        while (qsize(sel) == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, 128'(qsize(sel) != 0), 128'd1);
        if (qsize(sel) != 0) begin
            e = (sel == 1) ? wv1_q.pop_front() : wv3_q.pop_front();
            chk({tag, "_data"}, 128'(e.data), 128'(d));
            chk({tag, "_idx"},  128'(e.idx),  128'(idx));
            chk({tag, "_done"}, 128'(e.done), 128'(done));
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wv"},   128'(wv1), 128'd0);
        chk({tag, "_wd"},   128'(wd1), 128'd0);
        chk({tag, "_idx"},  128'(wi1), 128'd0);
        chk({tag, "_fd"},   128'(fd1), 128'd0);
        chk({tag, "_fe"},   128'(fe1), 128'd0);
        chk({tag, "_busy"}, 128'(bz1), 128'd0);
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] last_w;
        logic [DW-1:0] mw [3];
        int            n;
        int            d;

        // Reset state
        rstn = 1'b0;
        cycles(3);
        chk_reset_outputs("reset");
        rstn = 1'b1;
        en1  = 1'b1;
        cycles(2);

        // Single-word frame, 4-cycle link period
        w = {12'h813, 12'h70A, 12'h66D, 12'h5B8, 12'h4E1, 12'h39C, 12'h2A4, 12'h1F7};
        send_pulses(w, WW, 2, 2);
        expect_word("single", 1, w, 8'd0, 1'b1);
        cycles(4);
        chk("single_busy_after", 128'(bz1), 128'd0);
        last_w = w;

        // Random words with random link phases
        for (int k = 0; k < 6; k++) begin
            w = rnd_word();
            send_pulses(w, WW, int'($urandom_range(2, 4)), int'($urandom_range(2, 4)));
            expect_word("rand", 1, w, 8'd0, 1'b1);
            last_w = w;
        end
        chk("rand_no_extra", 128'(wv1_q.size()), 128'd0);

        // Truncated word: 7 pulses then idle
        w = rnd_word();
        send_pulses(w, 7, 2, 2);
        chk("trunc_busy", 128'(bz1), 128'd1);
        n = 0;
        while (err1_q.size() == 0 && n < TMO + 40) begin
            @(negedge clk);
            n++;
        end
        chk("trunc_err_seen", 128'(err1_q.size() != 0), 128'd1);
        if (err1_q.size() != 0) begin
            d = err1_q.pop_front() - last_rise;
            chk("trunc_err_latency", 128'((d >= TMO + 1) && (d <= TMO + 5)), 128'd1);
        end
        cycles(4);
        chk("trunc_single_err", 128'(err1_q.size()), 128'd0);
        chk("trunc_no_word", 128'(wv1_q.size()), 128'd0);
        chk("trunc_data_kept", 128'(wd1), 128'(last_w));
        chk("trunc_idle", 128'(bz1), 128'd0);
        w = rnd_word();
        send_pulses(w, WW, 2, 3);
        expect_word("after_trunc", 1, w, 8'd0, 1'b1);
        last_w = w;

        // Enable dropped mid-word
        w = rnd_word();
        send_pulses(w, 5, 3, 2);
        chk("endrop_busy_before", 128'(bz1), 128'd1);
        en1 = 1'b0;
        cycles(3);
        chk("endrop_busy", 128'(bz1), 128'd0);
        cycles(TMO + 20);
        chk("endrop_no_err", 128'(err1_q.size()), 128'd0);
        chk("endrop_no_word", 128'(wv1_q.size()), 128'd0);
        chk("endrop_data_kept", 128'(wd1), 128'(last_w));
        en1 = 1'b1;
        cycles(2);
        w = rnd_word();
        send_pulses(w, WW, 2, 2);
        expect_word("after_endrop", 1, w, 8'd0, 1'b1);

        // Reset pulse mid-word
        w = rnd_word();
        send_pulses(w, 8, 2, 2);
        rstn = 1'b0;
        cycles(1);
        chk_reset_outputs("midreset");
        rstn = 1'b1;
        cycles(TMO + 20);
        chk("midreset_no_err", 128'(err1_q.size()), 128'd0);
        w = rnd_word();
        send_pulses(w, WW, 4, 2);
        expect_word("after_reset", 1, w, 8'd0, 1'b1);

        // Three-word frames on the second instance
        en1 = 1'b0;
        en3 = 1'b1;
        cycles(2);
        mw[0] = {LANES{12'hAAA}};
        mw[1] = {LANES{12'h555}};
        mw[2] = {LANES{12'hF0F}};
        for (int k = 0; k < 3; k++) send_pulses(mw[k], WW, 2, 2);
        for (int k = 0; k < 3; k++) expect_word("multi", 3, mw[k], 8'(k), (k == 2));
        for (int k = 0; k < 3; k++) mw[k] = rnd_word();
        for (int k = 0; k < 3; k++)
            send_pulses(mw[k], WW, int'($urandom_range(2, 3)), int'($urandom_range(2, 3)));
        for (int k = 0; k < 3; k++) expect_word("multi_rand", 3, mw[k], 8'(k), (k == 2));
        cycles(4);
        chk("multi_busy_after", 128'(bz3), 128'd0);

        // Frame cut after one word: word_cnt!=0 with bit_cnt==0 still errors
        w = rnd_word();
        send_pulses(w, WW, 2, 2);
        expect_word("multi_part", 3, w, 8'd0, 1'b0);
        cycles(TMO + 20);
        chk("multi_part_err", 128'(err3_q.size()), 128'd1);
        chk("dut1_quiet", 128'(wv1_q.size() + err1_q.size()), 128'd0);
        chk("stray_done", 128'(stray1 + stray3), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
